// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register block: FSM states,
// acknowledge levels and pointer helpers.
package i2c_target_regs_pkg;

   // Protocol phases of the target.
   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      PTR,
      ACK_PTR,
      WRITE,
      ACK_WR,
      READ,
      MACK,
      IGNORE
   } state_t;

   // Acknowledge levels as seen on SDA.
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam int PTR_W     = 2;
   localparam int BIT_CNT_W = 4;

   // Register pointer increment, wrapping at the register count.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr,
                                                 input int nregs);
      return (int'(ptr) == nregs - 1) ? '0 : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_target_regs_line_sync.sv
// Brings SCL/SDA into the clk domain through 2-FF synchronizers and derives
// SCL edges plus START/STOP bus conditions from the synchronized values.
module i2c_target_regs_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   // [0],[1] form the synchronizer, [2] holds the previous synchronized value.
   logic [2:0] scl_sync_q, scl_sync_d;
   logic [2:0] sda_sync_q, sda_sync_d;
   logic       scl_s, scl_p, sda_p;

   // Shift the pad values through the synchronizer chain.
   always_comb begin
      scl_sync_d = {scl_sync_q[1:0], scl_in};
      sda_sync_d = {sda_sync_q[1:0], sda_in};
   end

   // Synchronizer flops; idle bus level is high on both lines.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
      end
   end

   assign scl_s = scl_sync_q[1];
   assign scl_p = scl_sync_q[2];
   assign sda   = sda_sync_q[1];
   assign sda_p = sda_sync_q[2];

   assign scl_rise  =  scl_s & ~scl_p;
   assign scl_fall  = ~scl_s &  scl_p;
   // Bus conditions only count while SCL has been high for two samples.
   assign start_det = scl_s & scl_p &  sda_p & ~sda;
   assign stop_det  = scl_s & scl_p & ~sda_p &  sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 4x8-bit register file. Write: address, pointer byte,
// then data bytes with auto-increment. Read: bytes from the current pointer
// with auto-increment while the master ACKs. SDA is open-drain: the pad
// wrapper does  assign sda = sda_oe ? 1'b0 : 1'bz.
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR  = 7'h48,
   parameter int          NREGS     = 4,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [31:0] out,
   output logic        busy,
   output logic        wr_strb
);

   logic sda, scl_rise, scl_fall, start_det, stop_det;

   i2c_target_regs_line_sync u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_t               state_q, state_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 rw_q, rw_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [31:0]          regs_q, regs_d;
   logic                 sda_oe_q, sda_oe_d;
   logic                 busy_q, busy_d;
   logic                 wr_strb_q, wr_strb_d;

   logic [7:0] rx_byte;
   logic [7:0] rd_byte;

   assign rx_byte = {shift_q[6:0], sda};
   assign rd_byte = regs_q[{ptr_q, 3'b000} +: 8];

   // Next-state and datapath: bus conditions first, then per-state bit handling.
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      rw_d      = rw_q;
      ptr_d     = ptr_q;
      regs_d    = regs_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      wr_strb_d = 1'b0;

      if (stop_det) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
         cnt_d    = '0;
      end else if (start_det) begin
         // Repeated START lands here too; the pointer is deliberately kept.
         state_d  = ADDR;
         busy_d   = 1'b1;
         sda_oe_d = 1'b0;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            IDLE, IGNORE: begin
            end

            ADDR, PTR, WRITE: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_q == BIT_CNT_W'(7)) begin
                     cnt_d = '0;
                     if (state_q == ADDR) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state_d = ACK_ADDR;
                           rw_d    = rx_byte[0];
                        end else begin
                           state_d = IGNORE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        state_d = ACK_PTR;
                     end else begin
                        regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
                        wr_strb_d = 1'b1;
                        ptr_d     = next_ptr(ptr_q, NREGS);
                        state_d   = ACK_WR;
                     end
                  end
               end
            end

            // cnt 0: drive ACK on the first fall; cnt 1: the next fall ends it.
            ACK_ADDR, ACK_PTR, ACK_WR: begin
               if (scl_fall) begin
                  if (cnt_q == '0) begin
                     sda_oe_d = 1'b1;
                     cnt_d    = BIT_CNT_W'(1);
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     if (state_q == ACK_ADDR && rw_q) begin
                        // The read byte is loaded on the fall that ends the ACK.
                        state_d  = READ;
                        shift_d  = {rd_byte[6:0], 1'b0};
                        sda_oe_d = ~rd_byte[7];
                        cnt_d    = BIT_CNT_W'(1);
                     end else if (state_q == ACK_ADDR) begin
                        state_d = PTR;
                     end else begin
                        state_d = WRITE;
                     end
                  end
               end
            end

            // cnt counts bits already driven; 0 means load the byte first.
            READ: begin
               if (scl_fall) begin
                  if (cnt_q == '0) begin
                     shift_d  = {rd_byte[6:0], 1'b0};
                     sda_oe_d = ~rd_byte[7];
                     cnt_d    = BIT_CNT_W'(1);
                  end else if (cnt_q == BIT_CNT_W'(8)) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = MACK;
                  end else begin
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b0};
                     cnt_d    = cnt_q + 1'b1;
                  end
               end
            end

            MACK: begin
               if (scl_rise) begin
                  if (sda == ACK) begin
                     ptr_d   = next_ptr(ptr_q, NREGS);
                     cnt_d   = '0;
                     state_d = READ;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, all returned to their idle values on reset.
   // NOTE: the register file is reset as well, since its reset contents are
   // part of the visible behaviour on the out port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         rw_q      <= 1'b0;
         ptr_q     <= '0;
         regs_q    <= RESET_VAL;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_strb_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         rw_q      <= rw_d;
         ptr_q     <= ptr_d;
         regs_q    <= regs_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         wr_strb_q <= wr_strb_d;
      end
   end

   assign sda_oe  = sda_oe_q;
   assign out     = regs_q;
   assign busy    = busy_q;
   assign wr_strb = wr_strb_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench: behavioural I2C master (SCL = clk/16) with pull-ups,
// a register/pointer model and a scoreboard for bytes and ACK bits.
module tb_i2c_target_regs;
   import i2c_target_regs_pkg::*;

   localparam logic [31:0] RESET_VAL = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_scl, m_sda;
   logic        sda_line;
   logic        sda_oe, busy, wr_strb;
   logic [31:0] out_w;

   int checks    = 0;
   int errors    = 0;
   int strb_cnt  = 0;
   int oe_hi_cnt = 0;

   logic [7:0] model_regs [4];
   logic [1:0] model_ptr;
   logic [7:0] none [$];

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q [$];

   always #5 clk = ~clk;

   // Open-drain bus with pull-up: the line is low if either side pulls it.
   assign sda_line = m_sda & ~sda_oe;

   i2c_target_regs #(
      .DEV_ADDR  (7'h48),
      .NREGS     (4),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .scl_in  (m_scl),
      .sda_in  (sda_line),
      .sda_oe  (sda_oe),
      .out     (out_w),
      .busy    (busy),
      .wr_strb (wr_strb)
   );

   always @(negedge clk) begin
      if (wr_strb) strb_cnt++;
      if (sda_oe)  oe_hi_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] act);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got %h expected nothing", act);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, act, e.val);
      end
   endtask

   function automatic logic [31:0] model_out();
      return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
   endfunction

   task automatic qw();
      repeat (4) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      m_sda = 1'b0; qw();
      m_scl = 1'b0; qw();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; qw();
      m_scl = 1'b1; qw();
      m_sda = 1'b1; qw();
      qw();
   endtask

   task automatic write_bit(input logic b);
      m_sda = b;    qw();
      m_scl = 1'b1; qw(); qw();
      m_scl = 1'b0; qw();
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      b = sda_line; qw();
      m_scl = 1'b0; qw();
   endtask

   task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic a;
      sb_push(tag, {31'b0, exp_ack});
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(a);
      sb_pop({31'b0, a});
   endtask

   task automatic read_byte(input logic [7:0] exp, input logic ack_bit, input string tag);
      logic [7:0] got;
      logic       b;
      sb_push(tag, {24'b0, exp});
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         got[i] = b;
      end
      sb_pop({24'b0, got});
      write_bit(ack_bit);
   endtask

   // Write transaction: address, pointer, data bytes, STOP.
   task automatic wr_regs(input logic [1:0] p, input logic [7:0] d [$]);
      i2c_start();
      write_byte(8'h90, ACK, "wr_addr_ack");
      check("busy_in_transfer", {31'b0, busy}, 32'd1);
      write_byte({6'b0, p}, ACK, "wr_ptr_ack");
      model_ptr = p;
      foreach (d[i]) begin
         write_byte(d[i], ACK, "wr_data_ack");
         model_regs[model_ptr] = d[i];
         model_ptr = model_ptr + 2'd1;
      end
      i2c_stop();
   endtask

   // Read body after the address: n bytes, ACK all but the last, NACK the last.
   task automatic rd_body(input int n);
      logic exp_rel;
      for (int k = 0; k < n; k++) begin
         read_byte(model_regs[model_ptr], (k == n - 1) ? NACK : ACK, "rd_data");
         if (k < n - 1) model_ptr = model_ptr + 2'd1;
      end
      exp_rel = 1'b0;
      check("sda_released_after_nack", {31'b0, sda_oe}, {31'b0, exp_rel});
      i2c_stop();
   endtask

   task automatic rd_txn(input int n);
      i2c_start();
      write_byte(8'h91, ACK, "rd_addr_ack");
      rd_body(n);
   endtask

   initial begin
      int   s0;
      logic exp_oe;
      logic [7:0] d [$];

      m_scl = 1'b1;
      m_sda = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) model_regs[i] = RESET_VAL[8*i +: 8];
      model_ptr = 2'd0;
      repeat (5) @(negedge clk);
      check("reset_sda_oe", {31'b0, sda_oe}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_wr_strb", {31'b0, wr_strb}, 32'd0);
      check("reset_out", out_w, RESET_VAL);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // 1: basic write of two bytes from pointer 0.
      s0 = strb_cnt;
      d = '{8'hA5, 8'h3C};
      wr_regs(2'd0, d);
      check("t1_out", out_w, model_out());
      check("t1_out_const", out_w, 32'h00003CA5);
      check("t1_wr_strb_count", strb_cnt - s0, 32'd2);
      check("t1_busy_after_stop", {31'b0, busy}, 32'd0);

      // 2: pointer wrap 3 -> 0 during a write.
      d = '{8'h11, 8'h22};
      wr_regs(2'd3, d);
      check("t2_out", out_w, model_out());
      check("t2_out_const", out_w, 32'h11003C22);

      // 3: set pointer, repeated START, read two bytes.
      i2c_start();
      write_byte(8'h90, ACK, "t3_addr_ack");
      write_byte(8'h01, ACK, "t3_ptr_ack");
      model_ptr = 2'd1;
      i2c_start();
      write_byte(8'h91, ACK, "t3_raddr_ack");
      rd_body(2);

      // Read straight after a write: current pointer is 3, wraps to 0.
      d = '{8'h5A};
      wr_regs(2'd2, d);
      rd_txn(2);

      // 4: foreign address is NACKed and the bus is left alone.
      s0 = oe_hi_cnt;
      i2c_start();
      write_byte(8'hA0, NACK, "t4_addr_nack");
      write_byte(8'h77, NACK, "t4_data_ignored");
      i2c_stop();
      check("t4_no_sda_activity", oe_hi_cnt - s0, 32'd0);
      check("t4_out_unchanged", out_w, model_out());

      // 5: STOP after 4 bits of a data byte.
      s0 = strb_cnt;
      i2c_start();
      write_byte(8'h90, ACK, "t5_addr_ack");
      write_byte(8'h00, ACK, "t5_ptr_ack");
      model_ptr = 2'd0;
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      i2c_stop();
      check("t5_out_unchanged", out_w, model_out());
      check("t5_no_wr_strb", strb_cnt - s0, 32'd0);
      check("t5_busy", {31'b0, busy}, 32'd0);

      // 0-byte write only moves the pointer.
      s0 = strb_cnt;
      wr_regs(2'd1, none);
      check("zero_byte_no_strb", strb_cnt - s0, 32'd0);
      rd_txn(1);

      // 6: reset while driving read data.
      i2c_start();
      write_byte(8'h91, ACK, "t6_addr_ack");
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      exp_oe = ~model_regs[model_ptr][7];
      check("t6_oe_before_reset", {31'b0, sda_oe}, {31'b0, exp_oe});
      #2 reset = 1'b1;
      #1;
      check("t6_oe_async_reset", {31'b0, sda_oe}, 32'd0);
      check("t6_out_reset", out_w, RESET_VAL);
      check("t6_busy_reset", {31'b0, busy}, 32'd0);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model_regs[i] = RESET_VAL[8*i +: 8];
      model_ptr = 2'd0;
      repeat (8) @(negedge clk);
      rd_txn(1);
      check("t6_out_after", out_w, model_out());

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
